// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad row scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} scan_state_t;

   localparam logic [3:0] ROW_IDLE  = 4'b1111;
   localparam logic [3:0] ROW_FIRST = 4'b1110;

   // True when exactly one bit of the active-low vector is driven low.
   function automatic logic is_one_cold(logic [3:0] v);
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] next_row(logic [3:0] r);
      return {r[2:0], r[3]};
   endfunction

endpackage

// File: rtl/keypad_sync_2ff.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all-ones (idle).
module keypad_sync_2ff #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_row_scanner.sv
// 4x4 keypad row scanner with column debounce and press/release tracking.
// Define KEYPAD_AUTOREPEAT_EN to repeat key_strobe while a key stays held.
module keypad_row_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 27000,
   parameter int unsigned SETTLE_CYCLES   = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned REPEAT_CYCLES   = 13500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] column_in,
   output logic [3:0] row_out,
   output logic [3:0] row_code,
   output logic [3:0] col_code,
   output logic       key_strobe,
   output logic       key_held
);

   localparam int unsigned MAX_A = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int unsigned MAX_P = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
   localparam int unsigned CNT_W = (MAX_P > 2) ? $clog2(MAX_P) : 1;

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] SETTLE_PT = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       w_col_s;
   scan_state_t      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_step_cnt, w_step_nxt;
   logic [CNT_W-1:0] r_deb_cnt, w_deb_nxt;
   logic [3:0]       r_cand_col, w_cand_nxt;
   logic [3:0]       r_row, w_row_nxt;
   logic [3:0]       r_row_code, w_row_code_nxt;
   logic [3:0]       r_col_code, w_col_code_nxt;
   logic             r_strobe, w_strobe_nxt;
   logic             r_held, w_held_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] r_rep_cnt, w_rep_nxt;
`endif

   keypad_sync_2ff #(
      .WIDTH(4)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .i_d(column_in),
      .o_q(w_col_s)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_step_nxt     = r_step_cnt;
      w_deb_nxt      = r_deb_cnt;
      w_cand_nxt     = r_cand_col;
      w_row_nxt      = r_row;
      w_row_code_nxt = r_row_code;
      w_col_code_nxt = r_col_code;
      w_strobe_nxt   = 1'b0;
      w_held_nxt     = r_held;
`ifdef KEYPAD_AUTOREPEAT_EN
      w_rep_nxt      = r_rep_cnt;
`endif
      case (r_state)
         SCAN: begin
            if (r_step_cnt == SETTLE_PT && is_one_cold(w_col_s)) begin
               w_cand_nxt  = w_col_s;
               w_deb_nxt   = '0;
               w_step_nxt  = '0;
               w_state_nxt = DEBOUNCE;
            end else if (r_step_cnt == SCAN_LAST) begin
               w_row_nxt  = next_row(r_row);
               w_step_nxt = '0;
            end else begin
               w_step_nxt = r_step_cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (w_col_s == r_cand_col) begin
               if (r_deb_cnt == DEB_LAST) begin
                  w_row_code_nxt = r_row;
                  w_col_code_nxt = r_cand_col;
                  w_strobe_nxt   = 1'b1;
                  w_held_nxt     = 1'b1;
                  w_deb_nxt      = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                  w_rep_nxt      = '0;
`endif
                  w_state_nxt    = HELD;
               end else begin
                  w_deb_nxt = r_deb_cnt + 1'b1;
               end
            end else begin
               // Bounce or glitch: abandon the candidate and move on to the next row.
               w_row_nxt   = next_row(r_row);
               w_step_nxt  = '0;
               w_deb_nxt   = '0;
               w_state_nxt = SCAN;
            end
         end
         HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (w_col_s == r_cand_col) begin
               if (r_rep_cnt == REP_LAST) begin
                  w_strobe_nxt = 1'b1;
                  w_rep_nxt    = '0;
               end else begin
                  w_rep_nxt = r_rep_cnt + 1'b1;
               end
            end else begin
               w_rep_nxt = '0;
            end
`endif
            if (w_col_s == ROW_IDLE) begin
               if (r_deb_cnt == DEB_LAST) begin
                  w_held_nxt  = 1'b0;
                  w_deb_nxt   = '0;
                  w_row_nxt   = next_row(r_row);
                  w_step_nxt  = '0;
                  w_state_nxt = SCAN;
               end else begin
                  w_deb_nxt = r_deb_cnt + 1'b1;
               end
            end else begin
               w_deb_nxt = '0;
            end
         end
         default: w_state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= SCAN;
         r_step_cnt <= '0;
         r_deb_cnt  <= '0;
         r_cand_col <= ROW_IDLE;
         r_row      <= ROW_FIRST;
         r_row_code <= ROW_IDLE;
         r_col_code <= ROW_IDLE;
         r_strobe   <= 1'b0;
         r_held     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep_cnt  <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_step_cnt <= w_step_nxt;
         r_deb_cnt  <= w_deb_nxt;
         r_cand_col <= w_cand_nxt;
         r_row      <= w_row_nxt;
         r_row_code <= w_row_code_nxt;
         r_col_code <= w_col_code_nxt;
         r_strobe   <= w_strobe_nxt;
         r_held     <= w_held_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep_cnt  <= w_rep_nxt;
`endif
      end
   end

   assign row_out    = r_row;
   assign row_code   = r_row_code;
   assign col_code   = r_col_code;
   assign key_strobe = r_strobe;
   assign key_held   = r_held;

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Randomized bench for keypad_row_scanner against a cycle-level behavioural keypad model.
module tb_keypad_row_scanner;

   localparam int SCAN_DIV = 8;
   localparam int SETTLE   = 2;
   localparam int DEB      = 5;
   localparam int REP      = 12;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] column_in;
   logic [3:0] row_out, row_code, col_code;
   logic       key_strobe, key_held;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: row index, phase within the row, stable-run counters.
   logic [3:0] m_sy1, m_sy2, m_cand, m_rc, m_cc;
   int         m_mode, m_row_idx, m_phase, m_run, m_rep;
   logic       m_strobe, m_held;

   // Stimulus: direct column drive or a physical key at (key_row, key_col).
   int         drv_mode;
   logic [3:0] drv_col;
   int         key_row;
   logic [3:0] key_col;
   logic       reached;

   keypad_row_scanner #(
      .SCAN_DIV(SCAN_DIV),
      .SETTLE_CYCLES(SETTLE),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .column_in(column_in),
      .row_out(row_out),
      .row_code(row_code),
      .col_code(col_code),
      .key_strobe(key_strobe),
      .key_held(key_held)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] row_val(input int idx);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << idx);
   endfunction

   task automatic model_reset();
      m_sy1 = 4'hF; m_sy2 = 4'hF; m_cand = 4'hF; m_rc = 4'hF; m_cc = 4'hF;
      m_mode = 0; m_row_idx = 0; m_phase = 0; m_run = 0; m_rep = 0;
      m_strobe = 1'b0; m_held = 1'b0;
   endtask

   task automatic model_leave();
      m_mode = 0;
      m_row_idx = (m_row_idx + 1) % 4;
      m_phase = 0;
      m_run = 0;
   endtask

   task automatic model_step(input logic [3:0] cin);
      logic [3:0] cs;
      cs = m_sy2;
      m_sy2 = m_sy1;
      m_sy1 = cin;
      m_strobe = 1'b0;
      if (m_mode == 0) begin
         if (m_phase == SETTLE && $countones(~cs) == 1) begin
            m_cand = cs; m_run = 0; m_phase = 0; m_mode = 1;
         end else if (m_phase == SCAN_DIV - 1) begin
            m_row_idx = (m_row_idx + 1) % 4;
            m_phase = 0;
         end else begin
            m_phase++;
         end
      end else if (m_mode == 1) begin
         if (cs == m_cand) begin
            m_run++;
            if (m_run == DEB) begin
               m_rc = row_val(m_row_idx); m_cc = m_cand;
               m_strobe = 1'b1; m_held = 1'b1;
               m_mode = 2; m_run = 0; m_rep = 0;
            end
         end else begin
            model_leave();
         end
      end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
         if (cs == m_cand) m_rep++;
         else m_rep = 0;
         if (m_rep == REP) begin
            m_strobe = 1'b1;
            m_rep = 0;
         end
`endif
         if (cs == 4'hF) m_run++;
         else m_run = 0;
         if (m_run == DEB) begin
            m_held = 1'b0;
            m_rep = 0;
            model_leave();
         end
      end
   endtask

   task automatic compare_all();
      check("row_out", row_out, row_val(m_row_idx));
      check("row_code", row_code, m_rc);
      check("col_code", col_code, m_cc);
      check("key_strobe", {3'b000, key_strobe}, {3'b000, m_strobe});
      check("key_held", {3'b000, key_held}, {3'b000, m_held});
   endtask

   function automatic logic [3:0] next_col();
      if (drv_mode == 1) return (row_out == row_val(key_row)) ? key_col : 4'hF;
      return drv_col;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         model_step(column_in);
         compare_all();
         column_in = next_col();
      end
   endtask

   task automatic apply(input logic [3:0] col, input int n);
      drv_mode = 0;
      drv_col = col;
      column_in = col;
      tick(n);
   endtask

   task automatic press(input int r, input logic [3:0] c, input int n);
      drv_mode = 1;
      key_row = r;
      key_col = c;
      column_in = next_col();
      tick(n);
   endtask

   initial begin
      drv_mode = 0; drv_col = 4'hF; key_row = 0; key_col = 4'hF;
      column_in = 4'hF;
      rst = 1'b1;
      model_reset();
      #3;
      compare_all();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle scanning through all rows.
      apply(4'hF, 40);

      // Key at row 1011 / column 1101.
      press(2, 4'b1101, 60);
      check("t2_held", {3'b000, key_held}, 4'b0001);
      check("t2_row_code", row_code, 4'b1011);
      check("t2_col_code", col_code, 4'b1101);

      // Release with one bounce back to the pressed column.
      apply(4'hF, 4);
      apply(4'b1101, 1);
      apply(4'hF, 12);
      check("t4_released", {3'b000, key_held}, 4'b0000);
      check("t4_row_resume", row_out, 4'b0111);

      // Short glitch on column 1110 while row 1110 is driven.
      reached = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (m_mode == 0 && m_row_idx == 0 && m_phase == 0) reached = 1'b1;
         else apply(4'hF, 1);
      end
      check("t3_reach_row0", {3'b000, reached}, 4'b0001);
      apply(4'b1110, 3);
      apply(4'hF, 4);
      check("t3_row_next", row_out, 4'b1101);
      check("t3_codes_kept", col_code, 4'b1101);

      // Two columns low is never accepted.
      apply(4'b1001, 40);
      check("t5_no_held", {3'b000, key_held}, 4'b0000);
      check("t5_codes_kept", row_code, 4'b1011);

      // Random presses with bounces and random releases.
      for (int it = 0; it < 25; it++) begin
         int kr;
         logic [3:0] kc;
         logic [3:0] one;
         one = 4'b0001;
         kr = int'($urandom_range(0, 3));
         kc = ~(one << $urandom_range(0, 3));
         repeat ($urandom_range(0, 4)) apply(4'($urandom()), 1);
         press(kr, kc, int'($urandom_range(0, 70)));
         repeat ($urandom_range(0, 3)) apply(4'($urandom()), 1);
         apply(4'hF, int'($urandom_range(0, 20)));
      end

`ifdef KEYPAD_AUTOREPEAT_EN
      press(3, 4'b1011, 100);
      apply(4'hF, 20);
`endif

      // Asynchronous reset while a candidate is being debounced.
      apply(4'hF, 10);
      reached = 1'b0;
      drv_mode = 1; key_row = 1; key_col = 4'b0111;
      column_in = next_col();
      for (int i = 0; i < 60 && !reached; i++) begin
         if (m_mode == 1) reached = 1'b1;
         else tick(1);
      end
      check("t6_reach_debounce", {3'b000, reached}, 4'b0001);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_row_out", row_out, 4'b1110);
      check("t6_rst_row_code", row_code, 4'b1111);
      check("t6_rst_col_code", col_code, 4'b1111);
      check("t6_rst_strobe", {3'b000, key_strobe}, 4'b0000);
      check("t6_rst_held", {3'b000, key_held}, 4'b0000);
      model_reset();
      drv_mode = 0; drv_col = 4'hF; column_in = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      apply(4'hF, 20);
      press(0, 4'b1110, 40);
      apply(4'hF, 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
